// File: rtl/serial_adder.sv
// serial_adder -- bit-serial ripple adder.
//
// One full-adder bit cell plus a carry flip-flop is reused over WIDTH clock
// cycles, consuming the operands LSB-first. A start/busy/done handshake
// frames each operation; sum/cout are registered and only change on the
// edge that enters DONE, so they hold the previous result during SHIFT.
//
// Optional feature (macro SERIAL_ADDER_SUB_EN): adds a 'sub' input sampled
// with start. With sub=1, b is captured inverted and the carry starts at 1,
// so sum = (a-b) mod 2^WIDTH and cout=1 means no borrow.
//
// Ports:
//   clk    in   system clock, rising edge
//   rst    in   asynchronous active-high reset
//   start  in   request a new operation (sampled in IDLE only)
//   sub    in   subtract select (only with SERIAL_ADDER_SUB_EN)
//   a, b   in   WIDTH-bit operands, captured on the accepting edge
//   busy   out  high in SHIFT and DONE
//   done   out  one-cycle pulse when sum/cout become valid
//   sum    out  WIDTH-bit registered result
//   cout   out  registered carry-out
//
// state | meaning
// IDLE  | waiting for start; outputs hold last result
// SHIFT | one operand bit per clock through the bit cell
// DONE  | result valid, done pulse; returns to IDLE next edge

module serial_adder #(
  parameter int WIDTH = 4,
  parameter int CW    = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_sr, b_sr, res_sr, res_nxt;
  logic [CW-1:0]    cnt;
  logic             carry, carry_nxt, bit_s, last;

  // Bit cell: full adder on the current LSBs and the carry flop.
  always_comb begin
    bit_s     = a_sr[0] ^ b_sr[0] ^ carry;
    carry_nxt = (a_sr[0] & b_sr[0]) | (a_sr[0] & carry) | (b_sr[0] & carry);
    // Written as shift-then-insert so WIDTH=1 needs no special slice.
    res_nxt          = res_sr >> 1;
    res_nxt[WIDTH-1] = bit_s;
    last             = (cnt == LAST);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = SHIFT;
      SHIFT:   if (last)  state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sr   <= '0;
      b_sr   <= '0;
      res_sr <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      sum    <= '0;
      cout   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_sr   <= a;
            res_sr <= '0;
            cnt    <= '0;
`ifdef SERIAL_ADDER_SUB_EN
            // Two's complement subtract: a + ~b + 1.
            b_sr   <= sub ? ~b : b;
            carry  <= sub;
`else
            b_sr   <= b;
            carry  <= 1'b0;
`endif
          end
        end
        SHIFT: begin
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          carry  <= carry_nxt;
          res_sr <= res_nxt;
          cnt    <= cnt + CW'(1);
          if (last) begin
            sum  <= res_nxt;
            cout <= carry_nxt;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
module tb_serial_adder;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [3:0] a, b;
  logic       busy, done, cout;
  logic [3:0] sum;
`ifdef SERIAL_ADDER_SUB_EN
  logic       sub_r = 1'b0;
`endif

  int total = 0;
  int bad   = 0;

  serial_adder #(.WIDTH(4), .CW(6)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
`ifdef SERIAL_ADDER_SUB_EN
    .sub   (sub_r),
`endif
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  always #5 clk = ~clk;

  // Launch one operation and wait (bounded) for done. n = edges from the
  // accepting edge to the first done sample, -1 on timeout. held = sum/cout
  // never moved before done. Operands are scrambled after acceptance.
  task automatic do_op(input logic [3:0] aa, input logic [3:0] bb,
                       output logic [3:0] s, output logic c, output int n,
                       output bit held, output logic busy0);
    int guard;
    logic [3:0] ps;
    logic pc;
    guard = 0;
    while (busy && guard < 50) begin
      @(posedge clk); #1; guard++;
    end
    @(negedge clk);
    a = aa; b = bb; start = 1'b1;
    ps = sum; pc = cout; held = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    a = 4'($urandom); b = 4'($urandom);
    busy0 = busy;
    n = 0;
    while (n < 40) begin
      @(posedge clk); #1; n++;
      if (done) break;
      if (sum !== ps || cout !== pc) held = 1'b0;
    end
    if (!done) n = -1;
    s = sum; c = cout;
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; a = 4'd0; b = 4'd0;
    #12;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", done); end
    total++; if (sum !== 4'd0) begin bad++; $display("FAIL reset_sum got=%h want=0", sum); end
    total++; if (cout !== 1'b0) begin bad++; $display("FAIL reset_cout got=%b want=0", cout); end
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_basic;
    logic [3:0] s; logic c, b0; int n; bit held;
    do_op(4'd3, 4'd5, s, c, n, held, b0);
    total++; if (b0 !== 1'b1) begin bad++; $display("FAIL basic_busy got=%b want=1", b0); end
    total++; if (n != 4) begin bad++; $display("FAIL basic_latency got=%0d want=4", n); end
    total++; if (s !== 4'b1000) begin bad++; $display("FAIL basic_sum got=%b want=1000", s); end
    total++; if (c !== 1'b0) begin bad++; $display("FAIL basic_cout got=%b want=0", c); end
    total++; if (!held) begin bad++; $display("FAIL basic_hold got=changed want=held"); end
    @(posedge clk); #1;
    total++; if (done !== 1'b0) begin bad++; $display("FAIL basic_done_width got=%b want=0", done); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL basic_busy_end got=%b want=0", busy); end
  endtask

  task automatic test_carry;
    logic [3:0] s; logic c, b0; int n; bit held;
    do_op(4'd15, 4'd1, s, c, n, held, b0);
    total++; if ({c, s} !== 5'b1_0000) begin bad++; $display("FAIL carry_15p1 got=%b want=10000", {c, s}); end
    do_op(4'd15, 4'd15, s, c, n, held, b0);
    total++; if ({c, s} !== 5'b1_1110) begin bad++; $display("FAIL carry_15p15 got=%b want=11110", {c, s}); end
    total++; if (!held) begin bad++; $display("FAIL carry_hold got=changed want=held"); end
    do_op(4'd1, 4'd2, s, c, n, held, b0);
    total++; if (!held) begin bad++; $display("FAIL hold_prev got=changed want=held"); end
    total++; if ({c, s} !== 5'b0_0011) begin bad++; $display("FAIL carry_1p2 got=%b want=00011", {c, s}); end
  endtask

  task automatic test_overlap;
    int guard, pulses;
    guard = 0;
    while (busy && guard < 50) begin @(posedge clk); #1; guard++; end
    @(negedge clk); a = 4'd2; b = 4'd2; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    @(posedge clk);
    @(negedge clk); a = 4'd7; b = 4'd7; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    guard = 2;
    while (!done && guard < 40) begin @(posedge clk); #1; guard++; end
    total++; if (guard != 4) begin bad++; $display("FAIL overlap_latency got=%0d want=4", guard); end
    total++; if ({cout, sum} !== 5'd4) begin bad++; $display("FAIL overlap_result got=%0d want=4", {cout, sum}); end
    pulses = 0;
    repeat (12) begin @(posedge clk); #1; if (done) pulses++; end
    total++; if (pulses != 0) begin bad++; $display("FAIL overlap_extra_done got=%0d want=0", pulses); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL overlap_busy got=%b want=0", busy); end
  endtask

  task automatic test_reset_mid;
    logic [3:0] s; logic c, b0; int n, pulses; bit held;
    @(negedge clk); a = 4'd9; b = 4'd9; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    @(posedge clk);
    @(posedge clk); #2; rst = 1'b1;
    #1;
    total++; if (sum !== 4'd0) begin bad++; $display("FAIL midrst_sum got=%h want=0", sum); end
    total++; if (cout !== 1'b0) begin bad++; $display("FAIL midrst_cout got=%b want=0", cout); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL midrst_busy got=%b want=0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL midrst_done got=%b want=0", done); end
    @(negedge clk); rst = 1'b0;
    pulses = 0;
    repeat (8) begin @(posedge clk); #1; if (done) pulses++; end
    total++; if (pulses != 0) begin bad++; $display("FAIL midrst_no_done got=%0d want=0", pulses); end
    do_op(4'd1, 4'd1, s, c, n, held, b0);
    total++; if ({c, s} !== 5'd2) begin bad++; $display("FAIL midrst_next got=%0d want=2", {c, s}); end
  endtask

  task automatic test_back_to_back;
    logic [3:0] s, aa, bb; logic c, b0; int n; bit held;
    logic [4:0] exp;
    for (int i = 0; i < 100; i++) begin
      aa = 4'($urandom); bb = 4'($urandom);
      exp = {1'b0, aa} + {1'b0, bb};
      do_op(aa, bb, s, c, n, held, b0);
      total++; if ({c, s} !== exp) begin bad++; $display("FAIL b2b_result a=%0d b=%0d got=%0d want=%0d", aa, bb, {c, s}, exp); end
      total++; if (n != 4) begin bad++; $display("FAIL b2b_latency got=%0d want=4", n); end
      @(posedge clk); #1;
      total++; if (done !== 1'b0) begin bad++; $display("FAIL b2b_done_width got=%b want=0", done); end
    end
  endtask

`ifdef SERIAL_ADDER_SUB_EN
  task automatic test_sub;
    logic [3:0] s; logic c, b0; int n; bit held;
    sub_r = 1'b1;
    do_op(4'd5, 4'd3, s, c, n, held, b0);
    total++; if ({c, s} !== 5'b1_0010) begin bad++; $display("FAIL sub_5m3 got=%b want=10010", {c, s}); end
    do_op(4'd3, 4'd5, s, c, n, held, b0);
    total++; if ({c, s} !== 5'b0_1110) begin bad++; $display("FAIL sub_3m5 got=%b want=01110", {c, s}); end
    sub_r = 1'b0;
    do_op(4'd3, 4'd5, s, c, n, held, b0);
    total++; if ({c, s} !== 5'b0_1000) begin bad++; $display("FAIL sub_off got=%b want=01000", {c, s}); end
  endtask
`endif

  initial begin
    test_reset;
    test_basic;
    test_carry;
    test_overlap;
    test_reset_mid;
    test_back_to_back;
`ifdef SERIAL_ADDER_SUB_EN
    test_sub;
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
- Bit-serial ripple adder built around a single registered half-adder/full-adder bit cell.
- Sits directly downstream of the half-adder stage: the lab's Sum/Cout bit cell is reused across clock cycles with a carry flip-flop.
- Adds two WIDTH-bit operands LSB-first, one bit per clock, under a start/busy/done handshake.
- Result and carry-out are held stable until the next operation completes.

Parameters:
- WIDTH, 4, operand and result width in bits; legal range 1..32.
- CW, 6, width of the internal bit counter; must satisfy 2^CW > WIDTH.

Ports:
- clk  input  1  single system clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request a new addition; sampled only in IDLE.
- a  input  WIDTH  operand A; captured on the accepting edge.
- b  input  WIDTH  operand B; captured on the accepting edge.
- busy  output  1  high while the block is in SHIFT or DONE.
- done  output  1  one-cycle pulse marking the cycle in which sum/cout first become valid.
- sum  output  WIDTH  registered result, (a+b) mod 2^WIDTH.
- cout  output  1  registered carry-out, bit WIDTH of a+b.

Behaviour:
- Reset (async, rst=1):
  - state=IDLE, carry=0, counter=0, operand/shift registers=0.
  - busy=0, done=0, sum=0, cout=0.
  - Takes effect immediately, regardless of clk.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - On an edge with start=1: latch a, b into shift registers, clear carry, counter=0, go to SHIFT.
  - With start=0: stay in IDLE; outputs hold.
- SHIFT, on each edge:
  - s = a_sr[0] ^ b_sr[0] ^ carry.
  - carry <= majority(a_sr[0], b_sr[0], carry).
  - a_sr, b_sr shift right by 1.
  - Result shift register shifts right with s inserted at the MSB.
  - counter increments.
  - On the edge where the counter reaches WIDTH-1: load the final result into sum, load the final carry into cout, go to DONE.
- DONE:
  - done=1 for exactly this one cycle.
  - Next edge returns to IDLE unconditionally.
- Latency:
  - start accepted at edge t0; done is high between edges t0+WIDTH and t0+WIDTH+1.
  - Next start is acceptable at edge t0+WIDTH+2.
  - Throughput is one operation per WIDTH+2 cycles.
- busy is 1 from edge t0 through the DONE cycle and 0 in IDLE.
- start asserted while busy=1 is ignored; the in-flight operation is unaffected and no request is queued.
- a and b may change after the accepting edge without effect on the result.
- sum and cout change only on the edge entering DONE; they hold the previous result throughout SHIFT.
- Reset asserted mid-operation aborts it: all outputs return to 0 and no done pulse is produced.
- WIDTH=1: the single SHIFT edge both computes the bit and enters DONE, so done appears 1 cycle after the accepting edge.

Optional Feature:
- Macro: SERIAL_ADDER_SUB_EN.
- Defined:
  - Adds input port sub (1 bit), sampled with start.
  - When sub=1, b is captured inverted and carry is initialised to 1, giving sum=(a-b) mod 2^WIDTH.
  - cout=1 means no borrow (a>=b).
  - When sub=0, behaviour is identical to the base block.
- Not defined: no sub port; the block is addition-only.

Test Plan:
- WIDTH=4, rst pulse, then a=3, b=5, start for 1 cycle -> busy=1 from the next edge; done pulses exactly 4 cycles after the accepting edge; sum=4'b1000, cout=0; busy=0 one cycle later.
- a=15, b=1 -> sum=0, cout=1. Then a=15, b=15 -> sum=4'b1110, cout=1.
- Start at t0 with a=2, b=2; reassert start with a=7, b=7 at t0+2 -> single done pulse with sum=4, cout=0; no second operation starts.
- Start a=9, b=9; assert rst at t0+2 mid-cycle (between edges) -> sum=0, cout=0, busy=0, done=0 immediately; no done pulse follows. Next start with a=1, b=1 -> sum=2.
- 100 random a/b pairs, back-to-back starts issued as soon as busy=0 -> every {cout,sum} equals a+b; done pulses are exactly one cycle wide.
- SERIAL_ADDER_SUB_EN defined: sub=1, a=5, b=3 -> sum=2, cout=1. Then sub=1, a=3, b=5 -> sum=4'b1110, cout=0.
